tlb_maint_unit: RTL and testbench
=================================

// Module: tlb_maint_unit
// PURPOSE
//  Executes LA32 TLB maintenance ops (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) issued from commit.
//  Keeps the authoritative mirror of every TLB entry.
//  Drives the one-hot tlb_write_req_t consumed by the translation mmu, so both arrays stay
//  identical by construction.
//  Sits between the commit/CSR stage (upstream) and the mmu's write port (downstream).
// PARAMETERS
//  TLB_ENTRY_NUM  `_TLB_ENTRY_NUM  entry count; power of two, 2..64
//  IDX_W          $clog2(TLB_ENTRY_NUM)  index width (localparam)
// PORTS
//  clk              in   1     clock
//  rst_n            in   1     asynchronous active-low reset
//  flush            in   1     pipeline flush from commit
//  req_valid        in   1     maintenance op valid
//  req_ready        out  1     unit can accept (1 only in IDLE)
//  req_op           in   3     tlb_op_e: SRCH/RD/WR/FILL/INV
//  req_invop        in   5     INVTLB op field
//  req_asid         in   10    INVTLB rj[9:0]
//  req_va           in   32    INVTLB rk
//  csr              in   csr_t tlbidx/tlbehi/tlbelo0/tlbelo1/asid/estat snapshot
//  resp_valid       out  1     result valid, held until resp_ready
//  resp_ready       in   1     commit accepts result
//  resp_o           out  tlb_maint_resp_t  {op, hit, idx, entry, ine}
//  tlb_write_req_o  out  tlb_write_req_t   one-hot/multi-hot write strobe + entry to mmu
// BEHAVIOUR
//  - Reset
//    - state=IDLE, resp_valid=0, resp_o='0, write strobe=0.
//    - Mirror key.e=0 for all entries.
//    - rand_q=0.
//  - FSM: IDLE -> EXEC -> RESP -> IDLE.
//    - Accept on req_valid & req_ready & ~flush; op fields and csr are latched.
//    - EXEC lasts exactly 1 cycle.
//    - RESP holds resp_valid=1 until resp_ready, then returns to IDLE.
//    - Minimum occupancy is 3 cycles per op; no back-to-back accept.
//  - Write strobe
//    - tlb_write_req_o.tlb_write_req is nonzero only in the EXEC cycle.
//    - The mirror updates on the same edge as the mmu.
//  - Entry build (WR/FILL)
//    - key.vppn=tlbehi[31:13]; key.huge_page=(tlbidx.ps==21); key.asid=csr.asid.
//    - key.g=elo0.g & elo1.g.
//    - key.e=(estat.ecode==`_ECODE_TLBR) ? 1 : ~tlbidx.ne.
//    - value[k] = {ppn,plv,mat,d,v} taken from tlbelo{k}.
//  - WR: target idx = tlbidx.index[IDX_W-1:0]; upper bits ignored.
//  - FILL
//    - Target = rand_q, a free-running counter incremented every cycle that wraps at
//      TLB_ENTRY_NUM-1 -> 0.
//    - The value is sampled in the EXEC cycle.
//  - SRCH
//    - Match rule: e & (g | asid==csr.asid) & vppn match, using huge-page compare on
//      vppn[18:9] vs tlbehi[31:22].
//    - Lowest matching index wins.
//    - Result: resp hit=1, idx=that index. No match: hit=0, idx=0. No write.
//  - RD
//    - resp entry = mirror[tlbidx.index]; hit = key.e.
//    - If e=0, entry is returned as '0 except e=0. No write.
//  - INV
//    - Single EXEC cycle with a multi-hot strobe; written payload is '0 (e=0).
//    - invop 0/1: all entries.
//    - invop 2: g=1.
//    - invop 3: g=0.
//    - invop 4: g=0 & asid==req_asid.
//    - invop 5: g=0 & asid & va match.
//    - invop 6: (g=1 | asid) & va match.
//    - va match for invop 5/6 uses req_va[31:13] with the huge-page rule.
//    - invop>6: no write, resp ine=1.
//  - Simultaneous events
//    - Flush in the accept cycle blocks the accept.
//    - Flush in EXEC does not cancel the write (op already committed).
//    - Flush in RESP drops resp_valid and returns to IDLE.
//    - Reset mid-op: back to reset state; any strobe is deasserted immediately (async).
//  - Width rules: all index math is modulo TLB_ENTRY_NUM; no out-of-range write ever issues.
// STRUCTURE
//  - Shared package a_mmu_defines gains:
//    - tlb_op_e
//    - tlb_maint_resp_t
//    - INVTLB op constants
//  - Existing tlb_key_t / tlb_value_t / tlb_entry_t / tlb_write_req_t are reused.
//  - One sub-module, tlb_match_vec: a combinational per-entry match vector shared by SRCH
//    and INV, with mode inputs {use_asid, use_va, g_sel}.
// TESTING
//  - WR idx=3: vppn=0x12345, ps=12, elo0.ppn=0xABCDE, v=1.
//    - EXEC cycle strobe=0x8.
//    - Then RD idx=3 returns the same entry, hit=1.
//  - SRCH on a duplicate match at idx 2 and 5 -> hit=1, idx=2.
//  - SRCH on a miss -> hit=0, idx=0; no strobe.
//  - FILL twice with 7 idle cycles in between -> target indices differ by 8 mod TLB_ENTRY_NUM.
//  - INV invop=4, asid=0x5: entries {g=0,asid=5}, {g=1,asid=5}, {g=0,asid=6}.
//    - Only the first is cleared.
//    - invop=7 -> ine=1, no strobe.
//  - Huge page ps=21, vppn[18:9]=0x1FF.
//    - SRCH with tlbehi[31:22]=0x1FF and arbitrary [21:13] -> hit.
//  - ESTAT ecode=TLBR with tlbidx.ne=1 on WR -> key.e=1.
//  - Flush during RESP -> resp_valid=0 next cycle, req_ready=1.
//  - rst_n low during EXEC -> strobe=0 immediately.

Source files
------------

// File: rtl/tlb_maint_unit_pkg.sv
// Shared MMU types for the TLB maintenance unit: CSR snapshot, TLB entry layout,
// maintenance op encodings and the write request consumed by the translation mmu.
package tlb_maint_unit_pkg;

    localparam int         TLB_MAX_ENTRY = 64;
    localparam logic [5:0] ECODE_TLBR    = 6'h3f;

    typedef enum logic [2:0] {
        TLB_OP_SRCH = 3'd0,
        TLB_OP_RD   = 3'd1,
        TLB_OP_WR   = 3'd2,
        TLB_OP_FILL = 3'd3,
        TLB_OP_INV  = 3'd4
    } tlb_op_e;

    localparam logic [4:0] INVTLB_ALL0       = 5'd0;
    localparam logic [4:0] INVTLB_ALL1       = 5'd1;
    localparam logic [4:0] INVTLB_G1         = 5'd2;
    localparam logic [4:0] INVTLB_G0         = 5'd3;
    localparam logic [4:0] INVTLB_G0_ASID    = 5'd4;
    localparam logic [4:0] INVTLB_G0_ASID_VA = 5'd5;
    localparam logic [4:0] INVTLB_GASID_VA   = 5'd6;

    // Global-bit qualifier used by the match vector.
    typedef enum logic [1:0] {
        G_ANY     = 2'd0,
        G_ONE     = 2'd1,
        G_ZERO    = 2'd2,
        G_OR_ASID = 2'd3
    } g_sel_e;

    typedef struct packed {
        logic        ne;
        logic [5:0]  ps;
        logic [15:0] index;
    } tlbidx_t;

    typedef struct packed {
        logic [19:0] ppn;
        logic        g;
        logic [1:0]  mat;
        logic [1:0]  plv;
        logic        d;
        logic        v;
    } tlbelo_t;

    typedef struct packed {
        tlbidx_t     tlbidx;
        logic [31:0] tlbehi;
        tlbelo_t     tlbelo0;
        tlbelo_t     tlbelo1;
        logic [9:0]  asid;
        logic [5:0]  ecode;
    } csr_t;

    typedef struct packed {
        logic [18:0] vppn;
        logic        huge_page;
        logic [9:0]  asid;
        logic        g;
        logic        e;
    } tlb_key_t;

    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } tlb_value_t;

    typedef struct packed {
        tlb_key_t            key;
        tlb_value_t [1:0]    value;
    } tlb_entry_t;

    typedef struct packed {
        logic [TLB_MAX_ENTRY-1:0] tlb_write_req;
        tlb_entry_t               entry;
    } tlb_write_req_t;

    typedef struct packed {
        tlb_op_e     op;
        logic        hit;
        logic [5:0]  idx;
        tlb_entry_t  entry;
        logic        ine;
    } tlb_maint_resp_t;

    function automatic tlb_value_t elo_to_value(input tlbelo_t elo);
        tlb_value_t val;
        val.ppn = elo.ppn;
        val.plv = elo.plv;
        val.mat = elo.mat;
        val.d   = elo.d;
        val.v   = elo.v;
        return val;
    endfunction

endpackage

// File: rtl/tlb_match_vec.sv
// Per-entry match vector over the TLB mirror, shared by TLBSRCH and INVTLB.
// Only valid entries (e=1) can match.
module tlb_match_vec
    import tlb_maint_unit_pkg::*;
#(
    parameter int N = 16
) (
    input  tlb_key_t    keys [N],
    input  logic [9:0]  asid,
    input  logic [18:0] vppn,
    input  logic        use_asid,
    input  logic        use_va,
    input  g_sel_e      g_sel,
    output logic [N-1:0] match
);

    always_comb begin
        match = '0;
        for (int i = 0; i < N; i++) begin
            logic asid_hit;
            logic va_hit;
            logic g_hit;
            asid_hit = (keys[i].asid == asid);
            // Huge pages only compare the upper 10 bits of the vppn.
            va_hit = keys[i].huge_page ? (keys[i].vppn[18:9] == vppn[18:9])
                                       : (keys[i].vppn == vppn);
            case (g_sel)
                G_ONE:     g_hit = keys[i].g & (~use_asid | asid_hit);
                G_ZERO:    g_hit = ~keys[i].g & (~use_asid | asid_hit);
                G_OR_ASID: g_hit = keys[i].g | asid_hit;
                default:   g_hit = ~use_asid | asid_hit;
            endcase
            match[i] = keys[i].e & g_hit & (~use_va | va_hit);
        end
    end

endmodule

// File: rtl/tlb_maint_unit.sv
// LA32 TLB maintenance unit: runs SRCH/RD/WR/FILL/INV from commit, keeps the
// authoritative entry mirror and drives the mmu write port from the same strobe.
module tlb_maint_unit
    import tlb_maint_unit_pkg::*;
#(
    parameter int TLB_ENTRY_NUM = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  tlb_op_e         req_op,
    input  logic [4:0]      req_invop,
    input  logic [9:0]      req_asid,
    input  logic [31:0]     req_va,
    input  csr_t            csr,
    output logic            resp_valid,
    input  logic            resp_ready,
    output tlb_maint_resp_t resp_o,
    output tlb_write_req_t  tlb_write_req_o
);

    localparam int IDX_W = $clog2(TLB_ENTRY_NUM);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e           state, state_n;
    tlb_entry_t       mirror [TLB_ENTRY_NUM];
    tlb_key_t         keys   [TLB_ENTRY_NUM];
    logic [IDX_W-1:0] rand_q;

    tlb_op_e          op_q;
    logic [4:0]       invop_q;
    logic [9:0]       asid_q;
    logic [18:0]      va_vppn_q;
    csr_t             csr_q;

    logic             use_asid, use_va;
    g_sel_e           g_sel;
    logic [9:0]       m_asid;
    logic [18:0]      m_vppn;
    logic [TLB_ENTRY_NUM-1:0] match, wr_vec;
    logic             srch_hit, ine;
    logic [IDX_W-1:0] srch_idx, wr_idx, rd_idx, tgt_idx;
    tlb_entry_t       new_entry, wr_entry, rd_entry;
    tlb_maint_resp_t  resp_d;
    logic             accept;

    assign accept     = (state == IDLE) && req_valid && !flush;
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign wr_idx     = csr_q.tlbidx.index[IDX_W-1:0];
    assign rd_idx     = csr_q.tlbidx.index[IDX_W-1:0];

    logic unused_bits;
    assign unused_bits = ^{req_va[12:0], csr_q.tlbehi[12:0], csr_q.tlbidx.index[15:IDX_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = EXEC;
            EXEC:    state_n = RESP;
            RESP:    if (flush || resp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Request fields are plain data: captured on accept, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q      <= req_op;
            invop_q   <= req_invop;
            asid_q    <= req_asid;
            va_vppn_q <= req_va[31:13];
            csr_q     <= csr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rand_q <= '0;
        else        rand_q <= rand_q + IDX_W'(1);
    end

    always_comb begin
        for (int i = 0; i < TLB_ENTRY_NUM; i++) keys[i] = mirror[i].key;
    end

    always_comb begin
        use_asid = 1'b0;
        use_va   = 1'b1;
        g_sel    = G_OR_ASID;
        m_asid   = csr_q.asid;
        m_vppn   = csr_q.tlbehi[31:13];
        if (op_q == TLB_OP_INV) begin
            use_va = 1'b0;
            g_sel  = G_ANY;
            m_asid = asid_q;
            m_vppn = va_vppn_q;
            case (invop_q)
                INVTLB_G1:         g_sel = G_ONE;
                INVTLB_G0:         g_sel = G_ZERO;
                INVTLB_G0_ASID:    begin g_sel = G_ZERO; use_asid = 1'b1; end
                INVTLB_G0_ASID_VA: begin g_sel = G_ZERO; use_asid = 1'b1; use_va = 1'b1; end
                INVTLB_GASID_VA:   begin g_sel = G_OR_ASID; use_va = 1'b1; end
                default:           ;
            endcase
        end
    end

    tlb_match_vec #(.N(TLB_ENTRY_NUM)) u_match (
        .keys     (keys),
        .asid     (m_asid),
        .vppn     (m_vppn),
        .use_asid (use_asid),
        .use_va   (use_va),
        .g_sel    (g_sel),
        .match    (match)
    );

    // Scan from the top so the lowest matching index is left standing.
    always_comb begin
        srch_hit = |match;
        srch_idx = '0;
        for (int i = TLB_ENTRY_NUM - 1; i >= 0; i--) begin
            if (match[i]) srch_idx = IDX_W'(i);
        end
    end

    always_comb begin
        new_entry               = '0;
        new_entry.key.vppn      = csr_q.tlbehi[31:13];
        new_entry.key.huge_page = (csr_q.tlbidx.ps == 6'd21);
        new_entry.key.asid      = csr_q.asid;
        new_entry.key.g         = csr_q.tlbelo0.g & csr_q.tlbelo1.g;
        new_entry.key.e         = (csr_q.ecode == ECODE_TLBR) ? 1'b1 : ~csr_q.tlbidx.ne;
        new_entry.value[0]      = elo_to_value(csr_q.tlbelo0);
        new_entry.value[1]      = elo_to_value(csr_q.tlbelo1);
    end

    always_comb begin
        rd_entry = mirror[rd_idx];
        if (!rd_entry.key.e) rd_entry = '0;
    end

    always_comb begin
        wr_vec   = '0;
        wr_entry = '0;
        tgt_idx  = '0;
        ine      = 1'b0;
        case (op_q)
            TLB_OP_WR: begin
                tgt_idx         = wr_idx;
                wr_vec[wr_idx]  = 1'b1;
                wr_entry        = new_entry;
            end
            TLB_OP_FILL: begin
                tgt_idx         = rand_q;
                wr_vec[rand_q]  = 1'b1;
                wr_entry        = new_entry;
            end
            TLB_OP_INV: begin
                if (invop_q <= INVTLB_GASID_VA)
                    wr_vec = (invop_q <= INVTLB_ALL1) ? '1 : match;
                else
                    ine = 1'b1;
            end
            default: ;
        endcase
    end

    // The strobe exists only in EXEC, so an async reset kills it at once.
    always_comb begin
        tlb_write_req_o                                  = '0;
        tlb_write_req_o.entry                            = wr_entry;
        if (state == EXEC)
            tlb_write_req_o.tlb_write_req[TLB_ENTRY_NUM-1:0] = wr_vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TLB_ENTRY_NUM; i++) mirror[i] <= '0;
        end else if (state == EXEC) begin
            for (int i = 0; i < TLB_ENTRY_NUM; i++)
                if (wr_vec[i]) mirror[i] <= wr_entry;
        end
    end

    always_comb begin
        resp_d     = '0;
        resp_d.op  = op_q;
        resp_d.ine = ine;
        case (op_q)
            TLB_OP_SRCH: begin
                resp_d.hit             = srch_hit;
                resp_d.idx[IDX_W-1:0]  = srch_idx;
            end
            TLB_OP_RD: begin
                resp_d.hit             = rd_entry.key.e;
                resp_d.idx[IDX_W-1:0]  = rd_idx;
                resp_d.entry           = rd_entry;
            end
            TLB_OP_WR, TLB_OP_FILL: begin
                resp_d.idx[IDX_W-1:0]  = tgt_idx;
                resp_d.entry           = new_entry;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             resp_o <= '0;
        else if (state == EXEC) resp_o <= resp_d;
    end

endmodule

// File: tb/tb_tlb_maint_unit.sv
// Directed bench for tlb_maint_unit: WR/RD round trip, SRCH priority and miss,
// FILL spacing, INVTLB selection, huge pages, TLBR refill, flush and reset cases.
module tb_tlb_maint_unit;
    import tlb_maint_unit_pkg::*;

    localparam int N = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            req_valid;
    logic            req_ready;
    tlb_op_e         req_op;
    logic [4:0]      req_invop;
    logic [9:0]      req_asid;
    logic [31:0]     req_va;
    csr_t            csr;
    logic            resp_valid;
    logic            resp_ready;
    tlb_maint_resp_t resp_o;
    tlb_write_req_t  tlb_write_req_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    tlb_maint_unit #(.TLB_ENTRY_NUM(N)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_invop       (req_invop),
        .req_asid        (req_asid),
        .req_va          (req_va),
        .csr             (csr),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_o          (resp_o),
        .tlb_write_req_o (tlb_write_req_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_csr(input int idx, input logic [18:0] vppn, input logic [5:0] ps,
                           input logic [9:0] asid, input logic g, input logic [19:0] ppn0);
        csr                = '0;
        csr.tlbidx.index   = idx[15:0];
        csr.tlbidx.ps      = ps;
        csr.tlbehi         = {vppn, 13'h0};
        csr.asid           = asid;
        csr.tlbelo0.ppn    = ppn0;
        csr.tlbelo0.v      = 1'b1;
        csr.tlbelo0.g      = g;
        csr.tlbelo1.g      = g;
    endtask

    // Issue one op, capture the EXEC-cycle strobe, then take the response.
    task automatic run_op(input tlb_op_e op, input logic [4:0] invop, input logic [9:0] asid,
                          input logic [31:0] va, output tlb_maint_resp_t r,
                          output logic [63:0] stb, output int ecyc);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_invop = invop;
        req_asid  = asid;
        req_va    = va;
        @(negedge clk);
        req_valid = 1'b0;
        stb       = tlb_write_req_o.tlb_write_req;
        ecyc      = cyc;
        @(negedge clk);
        for (int i = 0; i < 8 && !resp_valid; i++) @(negedge clk);
        chk("resp_valid", {127'b0, resp_valid}, 128'd1);
        r          = resp_o;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic simple_op(input tlb_op_e op, output tlb_maint_resp_t r, output logic [63:0] stb);
        int e;
        run_op(op, 5'd0, 10'd0, 32'd0, r, stb, e);
    endtask

    tlb_maint_resp_t r, r2;
    logic [63:0]     stb, stb2;
    int              e1, e2;
    tlb_entry_t      exp_e;
    logic [3:0]      dif;

    initial begin
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_op = TLB_OP_SRCH; req_invop = '0; req_asid = '0; req_va = '0; csr = '0;
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", {127'b0, resp_valid}, 128'd0);
        chk("rst_req_ready",  {127'b0, req_ready}, 128'd1);
        chk("rst_resp",       128'(resp_o), 128'd0);
        chk("rst_strobe",     128'(tlb_write_req_o.tlb_write_req), 128'd0);
        rst_n = 1'b1;

        // WR idx 3 then RD back
        set_csr(3, 19'h12345, 6'd12, 10'd0, 1'b0, 20'hABCDE);
        simple_op(TLB_OP_WR, r, stb);
        chk("wr_strobe", 128'(stb), 128'h8);
        exp_e = '0;
        exp_e.key.vppn = 19'h12345;
        exp_e.key.e = 1'b1;
        exp_e.value[0].ppn = 20'hABCDE;
        exp_e.value[0].v = 1'b1;
        csr = '0; csr.tlbidx.index = 16'd3;
        simple_op(TLB_OP_RD, r, stb);
        chk("rd_hit", {127'b0, r.hit}, 128'd1);
        chk("rd_entry", 128'(r.entry), 128'(exp_e));
        chk("rd_strobe", 128'(stb), 128'd0);

        // Duplicate match at 2 and 5: lowest wins
        set_csr(2, 19'h0AAAA, 6'd12, 10'd7, 1'b0, 20'h11111);
        simple_op(TLB_OP_WR, r, stb);
        set_csr(5, 19'h0AAAA, 6'd12, 10'd7, 1'b0, 20'h22222);
        simple_op(TLB_OP_WR, r, stb);
        set_csr(0, 19'h0AAAA, 6'd12, 10'd7, 1'b0, 20'h0);
        simple_op(TLB_OP_SRCH, r, stb);
        chk("srch_dup_hit", {127'b0, r.hit}, 128'd1);
        chk("srch_dup_idx", 128'(r.idx), 128'd2);
        chk("srch_dup_strobe", 128'(stb), 128'd0);

        set_csr(0, 19'h7FFFF, 6'd12, 10'd7, 1'b0, 20'h0);
        simple_op(TLB_OP_SRCH, r, stb);
        chk("srch_miss_hit", {127'b0, r.hit}, 128'd0);
        chk("srch_miss_idx", 128'(r.idx), 128'd0);
        chk("srch_miss_strobe", 128'(stb), 128'd0);

        // FILL twice, EXEC cycles 8 apart
        set_csr(0, 19'h01111, 6'd12, 10'd1, 1'b1, 20'h33333);
        run_op(TLB_OP_FILL, 5'd0, 10'd0, 32'd0, r, stb, e1);
        repeat (4) @(negedge clk);
        run_op(TLB_OP_FILL, 5'd0, 10'd0, 32'd0, r2, stb2, e2);
        dif = r2.idx[3:0] - r.idx[3:0];
        chk("fill_cycle_gap", 128'(e2 - e1), 128'd8);
        chk("fill_idx_gap", 128'(dif), 128'd8);
        chk("fill1_strobe", 128'(stb), 128'd1 << r.idx);
        chk("fill2_strobe", 128'(stb2), 128'd1 << r2.idx);

        // INVTLB op 4, asid 5
        set_csr(8, 19'h22222, 6'd12, 10'd5, 1'b0, 20'h1);
        simple_op(TLB_OP_WR, r, stb);
        set_csr(9, 19'h22222, 6'd12, 10'd5, 1'b1, 20'h2);
        simple_op(TLB_OP_WR, r, stb);
        set_csr(10, 19'h22222, 6'd12, 10'd6, 1'b0, 20'h3);
        simple_op(TLB_OP_WR, r, stb);
        run_op(TLB_OP_INV, 5'd4, 10'd5, 32'h0, r, stb, e1);
        chk("inv4_strobe", 128'(stb), 128'h100);
        chk("inv4_ine", {127'b0, r.ine}, 128'd0);
        csr = '0; csr.tlbidx.index = 16'd8;
        simple_op(TLB_OP_RD, r, stb);
        chk("inv4_rd8_hit", {127'b0, r.hit}, 128'd0);
        chk("inv4_rd8_entry", 128'(r.entry), 128'd0);
        csr.tlbidx.index = 16'd9;
        simple_op(TLB_OP_RD, r, stb);
        chk("inv4_rd9_hit", {127'b0, r.hit}, 128'd1);
        csr.tlbidx.index = 16'd10;
        simple_op(TLB_OP_RD, r, stb);
        chk("inv4_rd10_hit", {127'b0, r.hit}, 128'd1);
        run_op(TLB_OP_INV, 5'd7, 10'd5, 32'h0, r, stb, e1);
        chk("inv7_ine", {127'b0, r.ine}, 128'd1);
        chk("inv7_strobe", 128'(stb), 128'd0);

        // Huge page: only vppn[18:9] compared
        set_csr(12, {10'h1FF, 9'h0AB}, 6'd21, 10'd3, 1'b0, 20'h4);
        simple_op(TLB_OP_WR, r, stb);
        set_csr(0, {10'h1FF, 9'h155}, 6'd12, 10'd3, 1'b0, 20'h0);
        simple_op(TLB_OP_SRCH, r, stb);
        chk("huge_hit", {127'b0, r.hit}, 128'd1);
        chk("huge_idx", 128'(r.idx), 128'd12);

        // TLBR forces e=1 despite ne=1; without TLBR ne=1 leaves e=0
        set_csr(13, 19'h05555, 6'd12, 10'd2, 1'b0, 20'h5);
        csr.tlbidx.ne = 1'b1; csr.ecode = ECODE_TLBR;
        simple_op(TLB_OP_WR, r, stb);
        set_csr(14, 19'h06666, 6'd12, 10'd2, 1'b0, 20'h6);
        csr.tlbidx.ne = 1'b1;
        simple_op(TLB_OP_WR, r, stb);
        csr = '0; csr.tlbidx.index = 16'd13;
        simple_op(TLB_OP_RD, r, stb);
        chk("tlbr_e", {127'b0, r.hit}, 128'd1);
        csr.tlbidx.index = 16'd14;
        simple_op(TLB_OP_RD, r, stb);
        chk("ne_e", {127'b0, r.hit}, 128'd0);

        // Flush in accept cycle blocks the op
        @(negedge clk);
        req_valid = 1'b1; req_op = TLB_OP_SRCH; flush = 1'b1;
        @(negedge clk);
        chk("flush_accept_ready", {127'b0, req_ready}, 128'd1);
        chk("flush_accept_resp", {127'b0, resp_valid}, 128'd0);
        req_valid = 1'b0; flush = 1'b0;

        // Flush in RESP drops the response
        @(negedge clk);
        req_valid = 1'b1; req_op = TLB_OP_SRCH;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("flush_resp_pre", {127'b0, resp_valid}, 128'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_resp_valid", {127'b0, resp_valid}, 128'd0);
        chk("flush_resp_ready", {127'b0, req_ready}, 128'd1);

        // Reset during EXEC kills the strobe at once
        set_csr(1, 19'h07777, 6'd12, 10'd0, 1'b0, 20'h7);
        @(negedge clk);
        req_valid = 1'b1; req_op = TLB_OP_WR;
        @(negedge clk);
        req_valid = 1'b0;
        chk("exec_strobe", 128'(tlb_write_req_o.tlb_write_req), 128'h2);
        chk("exec_ready", {127'b0, req_ready}, 128'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_exec_strobe", 128'(tlb_write_req_o.tlb_write_req), 128'd0);
        chk("rst_exec_ready", {127'b0, req_ready}, 128'd1);
        @(negedge clk);
        rst_n = 1'b1;
        csr = '0; csr.tlbidx.index = 16'd3;
        simple_op(TLB_OP_RD, r, stb);
        chk("rst_mirror_e", {127'b0, r.hit}, 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
